// File: rtl/timers_timer2_ctrl.sv
// timers_timer2_ctrl: Timer2 sequencer owning the prescaler select/reset, 8-bit reload counter,
// overflow flag, overrun flag and interrupt request with acknowledge.
module timers_timer2_ctrl (
    input  logic       timers_timer2_ctrl_clock_i,
    input  logic       timers_timer2_ctrl_reset_i_b,
    input  logic       timers_sfr_tcon2_tr2_i,
    input  logic       timers_sfr_tcon2_mode_i,
    input  logic [2:0] timers_sfr_tcon2_dfp_i,
    input  logic       timers_sfr_th2_wr_i,
    input  logic [7:0] timers_sfr_th2_i,
    input  logic       timers_timer2_pdcf_clkdiv_i,
    input  logic       timers_timer2_irq_ack_i,
    output logic [2:0] timers_timer2_ctrl_dfp_o,
    output logic       timers_timer2_ctrl_pdcf_reset_o_b,
    output logic [7:0] timers_timer2_ctrl_count_o,
    output logic       timers_timer2_ctrl_tf2_o,
    output logic       timers_timer2_ctrl_ovr_o,
    output logic       timers_timer2_ctrl_irq_o,
    output logic       timers_timer2_ctrl_busy_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SYNC = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0] r_state, w_state_nx;
    logic [2:0] r_dfp, w_dfp_nx;
    logic [7:0] r_count, w_count_nx, r_reload;
    logic       r_clkdiv_q, r_tf2, r_ovr, r_irq;
    logic       w_tick, w_ovf, w_ack;

    // Select /1 counts every cycle; otherwise a rising edge of the divided clock is one tick.
    assign w_tick = (r_dfp == 3'd0) | (timers_timer2_pdcf_clkdiv_i & ~r_clkdiv_q);
    assign w_ack  = timers_timer2_irq_ack_i;

    always_comb begin
        w_state_nx = r_state;
        w_dfp_nx   = r_dfp;
        w_count_nx = r_count;
        w_ovf      = 1'b0;
        case (r_state)
            IDLE: begin
                if (timers_sfr_th2_wr_i)
                    w_count_nx = timers_sfr_th2_i;
                if (timers_sfr_tcon2_tr2_i) begin
                    w_state_nx = SYNC;
                    w_dfp_nx   = timers_sfr_tcon2_dfp_i;
                end
            end
            SYNC: w_state_nx = timers_sfr_tcon2_tr2_i ? RUN : IDLE;
            RUN: begin
                if (!timers_sfr_tcon2_tr2_i)
                    w_state_nx = IDLE;
                else if (timers_sfr_tcon2_dfp_i != r_dfp) begin
                    w_state_nx = SYNC;
                    w_dfp_nx   = timers_sfr_tcon2_dfp_i;
                end else if (w_tick) begin
                    if (r_count == 8'hFF) begin
                        w_ovf      = 1'b1;
                        w_count_nx = r_reload;
                        w_state_nx = timers_sfr_tcon2_mode_i ? DONE : RUN;
                    end else
                        w_count_nx = r_count + 8'd1;
                end
            end
            default: w_state_nx = timers_sfr_tcon2_tr2_i ? DONE : IDLE;
        endcase
    end

    always_ff @(posedge timers_timer2_ctrl_clock_i or negedge timers_timer2_ctrl_reset_i_b) begin
        if (!timers_timer2_ctrl_reset_i_b) begin
            r_state    <= IDLE;
            r_dfp      <= 3'b000;
            r_count    <= 8'h00;
            r_reload   <= 8'h00;
            r_clkdiv_q <= 1'b1;
            r_tf2      <= 1'b0;
            r_ovr      <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_dfp      <= w_dfp_nx;
            r_count    <= w_count_nx;
            r_reload   <= timers_sfr_th2_wr_i ? timers_sfr_th2_i : r_reload;
            r_clkdiv_q <= (r_state == SYNC) | timers_timer2_pdcf_clkdiv_i;
            r_tf2      <= w_ovf | (r_tf2 & ~w_ack);
            r_irq      <= w_ovf | (r_irq & ~w_ack);
            r_ovr      <= w_ovf ? (r_tf2 | (r_ovr & ~w_ack)) : (r_ovr & ~w_ack);
        end
    end

    assign timers_timer2_ctrl_dfp_o          = r_dfp;
    assign timers_timer2_ctrl_pdcf_reset_o_b = (r_state == RUN);
    assign timers_timer2_ctrl_busy_o         = (r_state == SYNC);
    assign timers_timer2_ctrl_count_o        = r_count;
    assign timers_timer2_ctrl_tf2_o          = r_tf2;
    assign timers_timer2_ctrl_ovr_o          = r_ovr;
    assign timers_timer2_ctrl_irq_o          = r_irq;
endmodule

// File: tb/tb_timers_timer2_ctrl.sv
// tb_timers_timer2_ctrl: vector table and scoreboard bench with a behavioural prescaler.
module tb_timers_timer2_ctrl;
    logic       clk, rst_n, tr2, mode, wr, ack;
    logic [2:0] dfp;
    logic [7:0] th2;
    logic [2:0] dfp_o;
    logic       pdcf_b, tf2, ovr, irq, busy;
    logic [7:0] count;
    logic [7:0] pre_cnt;
    logic       pre_div;
    int         n_pass, n_total;

    typedef struct {
        logic       tr2, mode;
        logic [2:0] dfp;
        logic       wr;
        logic [7:0] th2;
        logic       ack;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];

    timers_timer2_ctrl dut (
        .timers_timer2_ctrl_clock_i        (clk),
        .timers_timer2_ctrl_reset_i_b      (rst_n),
        .timers_sfr_tcon2_tr2_i            (tr2),
        .timers_sfr_tcon2_mode_i           (mode),
        .timers_sfr_tcon2_dfp_i            (dfp),
        .timers_sfr_th2_wr_i               (wr),
        .timers_sfr_th2_i                  (th2),
        .timers_timer2_pdcf_clkdiv_i       (pre_div),
        .timers_timer2_irq_ack_i           (ack),
        .timers_timer2_ctrl_dfp_o          (dfp_o),
        .timers_timer2_ctrl_pdcf_reset_o_b (pdcf_b),
        .timers_timer2_ctrl_count_o        (count),
        .timers_timer2_ctrl_tf2_o          (tf2),
        .timers_timer2_ctrl_ovr_o          (ovr),
        .timers_timer2_ctrl_irq_o          (irq),
        .timers_timer2_ctrl_busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Prescaler: counter cleared while held, registered divided clock from bit dfp-1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= 8'd0;
            pre_div <= 1'b0;
        end else if (!pdcf_b) begin
            pre_cnt <= 8'd0;
            pre_div <= 1'b0;
        end else begin
            pre_cnt <= pre_cnt + 8'd1;
            pre_div <= (dfp_o == 3'd0) ? 1'b0 : pre_cnt[dfp_o - 3'd1];
        end
    end

    function automatic logic [15:0] outs(input logic [7:0] c, input logic [2:0] d,
                                         input logic t, o, i, b, p);
        return {c, d, t, o, i, b, p};
    endfunction

    function automatic vec_t mk(input logic t_r, m, input logic [2:0] d, input logic w,
                                input logic [7:0] v, input logic a, input logic [15:0] e);
        vec_t r;
        r.tr2 = t_r; r.mode = m; r.dfp = d; r.wr = w; r.th2 = v; r.ack = a; r.exp = e;
        return r;
    endfunction

    function automatic logic [15:0] dut_outs();
        return {count, dfp_o, tf2, ovr, irq, busy, pdcf_b};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got count=%h dfp=%b tf2/ovr/irq/busy/pdcf=%b, want count=%h dfp=%b tf2/ovr/irq/busy/pdcf=%b",
                      name, act[15:8], act[7:5], act[4:0], exp[15:8], exp[7:5], exp[4:0]);
    endtask

    task automatic step(input string name, input vec_t v);
        sb_t e;
        tr2 = v.tr2; mode = v.mode; dfp = v.dfp; wr = v.wr; th2 = v.th2; ack = v.ack;
        e.name = name; e.exp = v.exp;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check(e.name, dut_outs(), e.exp);
    endtask

    task automatic add(input logic t_r, m, input logic [2:0] d, input logic w, input logic [7:0] v,
                       input logic a, input logic [7:0] c, input logic [2:0] od,
                       input logic t, o, i, b, p);
        vecs.push_back(mk(t_r, m, d, w, v, a, outs(c, od, t, o, i, b, p)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; tr2 = 0; mode = 0; dfp = 0; wr = 0; th2 = 0; ack = 0;

        // auto-reload /1 with interrupt handshake
        add(0,0,0,1,8'hFC,0, 8'hFC,0,0,0,0,0,0);
        add(1,0,0,0,0,0,     8'hFC,0,0,0,0,1,0);
        add(1,0,0,0,0,0,     8'hFC,0,0,0,0,0,1);
        add(1,0,0,0,0,0,     8'hFD,0,0,0,0,0,1);
        add(1,0,0,0,0,0,     8'hFE,0,0,0,0,0,1);
        add(1,0,0,0,0,0,     8'hFF,0,0,0,0,0,1);
        add(1,0,0,0,0,0,     8'hFC,0,1,0,1,0,1);
        add(1,0,0,0,0,0,     8'hFD,0,1,0,1,0,1);
        add(1,0,0,0,0,0,     8'hFE,0,1,0,1,0,1);
        add(1,0,0,0,0,0,     8'hFF,0,1,0,1,0,1);
        add(1,0,0,0,0,0,     8'hFC,0,1,1,1,0,1);
        add(1,0,0,0,0,0,     8'hFD,0,1,1,1,0,1);
        add(1,0,0,0,0,0,     8'hFE,0,1,1,1,0,1);
        add(1,0,0,0,0,0,     8'hFF,0,1,1,1,0,1);
        add(1,0,0,0,0,1,     8'hFC,0,1,1,1,0,1);
        add(1,0,0,0,0,1,     8'hFD,0,0,0,0,0,1);
        add(0,0,0,0,0,0,     8'hFD,0,0,0,0,0,0);
        // /8 cadence
        add(0,0,3,1,8'h00,0, 8'h00,0,0,0,0,0,0);
        add(1,0,3,0,0,0,     8'h00,3,0,0,0,1,0);
        add(1,0,3,0,0,0,     8'h00,3,0,0,0,0,1);
        for (int k = 1; k <= 14; k++)
            add(1,0,3,0,0,0, (k < 6) ? 8'h00 : (k < 14) ? 8'h01 : 8'h02, 3,0,0,0,0,1);
        add(0,0,3,0,0,0,     8'h02,3,0,0,0,0,0);
        // select change 011 -> 001 with count held at 10
        add(0,0,3,1,8'h10,0, 8'h10,3,0,0,0,0,0);
        add(1,0,3,0,0,0,     8'h10,3,0,0,0,1,0);
        add(1,0,3,0,0,0,     8'h10,3,0,0,0,0,1);
        add(1,0,3,0,0,0,     8'h10,3,0,0,0,0,1);
        add(1,0,3,0,0,0,     8'h10,3,0,0,0,0,1);
        add(1,0,1,0,0,0,     8'h10,1,0,0,0,1,0);
        add(1,0,1,0,0,0,     8'h10,1,0,0,0,0,1);
        for (int k = 1; k <= 6; k++)
            add(1,0,1,0,0,0, (k < 3) ? 8'h10 : (k < 5) ? 8'h11 : 8'h12, 1,0,0,0,0,1);
        add(0,0,1,0,0,0,     8'h12,1,0,0,0,0,0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_outs(), outs(8'h00,0,0,0,0,0,0));
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            step($sformatf("vec%0d", i), vecs[i]);

        // one-shot: overflow parks in DONE, idle write loads count at once
        step("os_load",  mk(0,1,0,1,8'hFE,0, outs(8'hFE,1,0,0,0,0,0)));
        step("os_sync",  mk(1,1,0,0,0,0,     outs(8'hFE,0,0,0,0,1,0)));
        step("os_run",   mk(1,1,0,0,0,0,     outs(8'hFE,0,0,0,0,0,1)));
        step("os_ff",    mk(1,1,0,0,0,0,     outs(8'hFF,0,0,0,0,0,1)));
        step("os_ovf",   mk(1,1,0,0,0,0,     outs(8'hFE,0,1,0,1,0,0)));
        step("os_done1", mk(1,1,0,0,0,0,     outs(8'hFE,0,1,0,1,0,0)));
        step("os_done2", mk(1,1,0,0,0,0,     outs(8'hFE,0,1,0,1,0,0)));
        step("os_idle",  mk(0,1,0,0,0,0,     outs(8'hFE,0,1,0,1,0,0)));
        step("os_wr20",  mk(0,1,0,1,8'h20,0, outs(8'h20,0,1,0,1,0,0)));

        // async reset between edges while counting at /4
        step("ar_sync",  mk(1,0,2,0,0,0, outs(8'h20,2,1,0,1,1,0)));
        step("ar_run",   mk(1,0,2,0,0,0, outs(8'h20,2,1,0,1,0,1)));
        for (int k = 1; k <= 5; k++)
            step($sformatf("ar_k%0d", k), mk(1,0,2,0,0,0, outs((k < 4) ? 8'h20 : 8'h21,2,1,0,1,0,1)));
        #3 rst_n = 1'b0;
        #1 check("async_reset", dut_outs(), outs(8'h00,0,0,0,0,0,0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        step("post_reset", mk(0,0,0,0,0,0, outs(8'h00,0,0,0,0,0,0)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/timers_timer2_ctrl.md
# timers_timer2_ctrl

Timer2 control sequencer for the EMC08 timer subsystem. It owns the Timer2 prescaler (`timers_timer2_pdcf`), applying its divide-select, holding it cleared when idle and re-aligning it when the select changes. It turns the prescaler's divided-clock level into count ticks for an 8-bit up-counter with reload. It raises the overflow flag and interrupt request, with an acknowledge handshake, and supports auto-reload and one-shot modes.

## Interface
Parameters: none (widths fixed by the SFR map).
- timers_timer2_ctrl_clock_i  in  1  system clock; all state on rising edge
- timers_timer2_ctrl_reset_i_b  in  1  asynchronous, active-low reset
- timers_sfr_tcon2_tr2_i  in  1  run enable (level)
- timers_sfr_tcon2_mode_i  in  1  0 = auto-reload, 1 = one-shot
- timers_sfr_tcon2_dfp_i  in  3  requested prescaler select, 000 = /1 … 111 = /128
- timers_sfr_th2_wr_i  in  1  reload-register write strobe (one cycle)
- timers_sfr_th2_i  in  8  reload value
- timers_timer2_pdcf_clkdiv_i  in  1  divided-clock level from prescaler
- timers_timer2_irq_ack_i  in  1  interrupt acknowledge (one cycle)
- timers_timer2_ctrl_dfp_o  out  3  applied prescaler select, to prescaler
- timers_timer2_ctrl_pdcf_reset_o_b  out  1  prescaler synchronous reset, active low
- timers_timer2_ctrl_count_o  out  8  current count
- timers_timer2_ctrl_tf2_o  out  1  overflow flag
- timers_timer2_ctrl_ovr_o  out  1  overrun: overflow while tf2 already set
- timers_timer2_ctrl_irq_o  out  1  interrupt request
- timers_timer2_ctrl_busy_o  out  1  high in SYNC state (select change in progress)

## Operation
- The FSM has four states: IDLE, SYNC, RUN and DONE.
- Reset values: state IDLE; reload 8'h00; count 8'h00; dfp_o 3'b000; tf2, ovr and irq 0; edge-detect register 1.
- pdcf_reset_o_b = 1 only in RUN. In all other states it is 0, so the prescaler is held cleared.
- busy_o = 1 only in SYNC.
- IDLE:
  - On tr2 = 1, go to SYNC and latch dfp_o <= dfp_i.
  - Count holds its value.
- SYNC (exactly one cycle):
  - Edge-detect register is forced to 1.
  - Next state is RUN, or IDLE if tr2 = 0.
- RUN, priority high to low:
  - tr2 = 0 → IDLE; count holds and any tick in this cycle is dropped.
  - dfp_i != dfp_o → SYNC, latch the new dfp_o; count holds and the tick is dropped.
  - tick → count increments.
- Tick generation:
  - If dfp_o = 000, tick = 1 every RUN cycle.
  - Otherwise, tick = clkdiv_i & ~clkdiv_q, where clkdiv_q is the registered previous clkdiv_i.
  - Forcing clkdiv_q to 1 in SYNC means a stale high level from the prescaler never produces a tick.
- Overflow is a tick while count = 8'hFF. On overflow:
  - count <= reload (no 8'h00 state is passed through).
  - tf2 and irq are set.
  - ovr is set if tf2 was already 1.
  - In mode 1 (one-shot), the FSM goes to DONE.
- DONE: count holds the reload value; tr2 = 0 → IDLE.
- Reload write (th2_wr_i = 1):
  - The reload register is updated every time.
  - In IDLE, count is also loaded the same cycle.
  - In SYNC, RUN or DONE, count is unaffected; the new value takes effect at the next overflow.
- Acknowledge:
  - irq_ack_i = 1 clears tf2, irq and ovr.
  - If an overflow occurs in the same cycle, set wins: tf2 and irq stay 1, and ovr becomes 1 only if tf2 was 1 before that cycle.
- A mode change while in RUN takes effect at the next overflow.
- Asserting reset at any point returns all state to the reset values immediately, without waiting for a clock edge.

## Timing
- All outputs are registered, except pdcf_reset_o_b and busy_o, which are decoded from the state register.
- Start-up: tr2 rises before edge E0 (enter SYNC), then E1 (enter RUN).
- First increment, counting RUN edges from 1 after E1:
  - For dfp = 000: at RUN edge 1, then every cycle.
  - For dfp = d > 0: at RUN edge 2^(d-1)+2, then every 2^d cycles.
- Latency from clkdiv_i rising to the count update: 1 clock.
- Overflow to tf2/irq high: same edge as the count reload.
- Ack to irq low: next edge.
- A select change costs one SYNC cycle plus the first-tick latency above. No partial-period tick is ever produced.

## Test plan
- Auto-reload, /1:
  - Stimulus: reload = 8'hFC, mode 0, dfp 000, tr2 = 1.
  - Required: count runs FC, FD, FE, FF, FC with one increment per clock; tf2 and irq rise with the FF→FC edge; busy_o is high for exactly 1 cycle at start.
- /8 cadence:
  - Stimulus: dfp = 011, reload 8'h00.
  - Required: first increment 6 clocks after RUN entry; subsequent increments every 8 clocks; pdcf_reset_o_b low in IDLE and SYNC.
- Select change mid-run:
  - Stimulus: change from 011 to 001 while count = 8'h10.
  - Required: one SYNC cycle; dfp_o = 001; count holds 8'h10; the next increment occurs 3 clocks after RUN re-entry, then every 2 clocks.
- One-shot:
  - Stimulus: mode 1, reload 8'hFE, dfp 000.
  - Required: count FE, FF, FE; FSM in DONE; count frozen; clearing tr2 → IDLE; a th2 write of 8'h20 loads count to 8'h20 immediately.
- Interrupt handshake:
  - Stimulus: second overflow with no ack.
  - Required: ovr = 1.
  - Stimulus: ack coincident with an overflow.
  - Required: tf2 and irq stay 1.
  - Stimulus: ack alone.
  - Required: tf2, irq and ovr all 0 on the next edge.
- Async reset mid-count:
  - Stimulus: assert reset_i_b low between clock edges.
  - Required: count = 00, dfp_o = 000, all flags 0 and pdcf_reset_o_b = 0 immediately, before the next clock edge.
